// File: rtl/exe_operand_fetch_pkg.sv
// Shared widths, buffer-state encoding and the captured-entry record for exe_operand_fetch.
package exe_operand_fetch_pkg;

  localparam int XLEN        = 32;
  localparam int REG_NUM     = 32;
  localparam int REG_IDX_W   = 5;
  localparam int InstIDDepth = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [6:0]           opcode;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_vld;
    logic [XLEN-1:0]      imm;
    logic [11:0]          csr;
    logic                 csr_vld;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
  } entry_t;

  // A held entry tracks register writes that land after it captured its operands.
  function automatic entry_t snoop_entry(entry_t e, logic wb_en,
                                         logic [REG_IDX_W-1:0] wb_rd,
                                         logic [XLEN-1:0] wb_data);
    entry_t r;
    r = e;
    if (wb_en && (wb_rd != '0)) begin
      if (wb_rd == e.rs1) r.rs1_data = wb_data;
      if (wb_rd == e.rs2) r.rs2_data = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/exe_operand_fetch_regfile.sv
// 32x32 register file: two combinational read ports (x0 reads 0), one synchronous write port,
// synchronous active-low clear.
module exe_regfile
  import exe_operand_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [XLEN-1:0]      wd
);

  logic [XLEN-1:0] mem_q [REG_NUM];
  logic            wr_d;

  always_comb begin
    wr_d = we && (wa != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) mem_q[i] <= '0;
    end else if (wr_d) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/exe_operand_fetch.sv
// Execute-side operand fetch: valid/ready intake, register-file read, main+skid issue buffer
// with writeback snoop. Optional same-cycle writeback bypass at accept: `WB_BYPASS_EN.
module exe_operand_fetch
  import exe_operand_fetch_pkg::*;
#(
  parameter int INST_ID_W = InstIDDepth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [6:0]           in_opcode,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_vld,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [INST_ID_W-1:0] in_instID,
  input  logic [11:0]          in_csr,
  input  logic                 in_csr_vld,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [XLEN-1:0]      out_pc,
  output logic [6:0]           out_opcode,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_vld,
  output logic [XLEN-1:0]      out_imm,
  output logic [INST_ID_W-1:0] out_instID,
  output logic [11:0]          out_csr,
  output logic                 out_csr_vld,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output buf_state_e           dbg_state
);

  // Handshake: a transfer happens on a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and ready here is a pure function of state.
  buf_state_e           state_q, state_d;
  entry_t               main_q, main_d, skid_q, skid_d;
  logic [INST_ID_W-1:0] main_id_q, main_id_d, skid_id_q, skid_id_d;
  entry_t               new_e, main_snp, skid_snp;
  logic [XLEN-1:0]      rf_rs1, rf_rs2;
  logic                 accept, handoff;

  exe_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (in_rs1),
    .ra2   (in_rs2),
    .rd1   (rf_rs1),
    .rd2   (rf_rs2),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  assign in_rdy  = (state_q != FULL);
  assign out_vld = (state_q != EMPTY);
  assign accept  = in_vld && in_rdy && !flush;
  assign handoff = out_vld && out_rdy;

  always_comb begin
    new_e          = '0;
    new_e.pc       = in_pc;
    new_e.opcode   = in_opcode;
    new_e.rs1      = in_rs1;
    new_e.rs2      = in_rs2;
    new_e.rd       = in_rd;
    new_e.rd_vld   = in_rd_vld;
    new_e.imm      = in_imm;
    new_e.csr      = in_csr;
    new_e.csr_vld  = in_csr_vld;
`ifdef WB_BYPASS_EN
    new_e.rs1_data = (wb_en && (wb_rd != '0) && (wb_rd == in_rs1)) ? wb_data : rf_rs1;
    new_e.rs2_data = (wb_en && (wb_rd != '0) && (wb_rd == in_rs2)) ? wb_data : rf_rs2;
`else
    new_e.rs1_data = rf_rs1;
    new_e.rs2_data = rf_rs2;
`endif
  end

  always_comb begin
    main_snp  = snoop_entry(main_q, wb_en, wb_rd, wb_data);
    skid_snp  = snoop_entry(skid_q, wb_en, wb_rd, wb_data);
    state_d   = state_q;
    main_d    = main_snp;
    skid_d    = skid_snp;
    main_id_d = main_id_q;
    skid_id_d = skid_id_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d    = new_e;
          main_id_d = in_instID;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (accept && handoff) begin
          main_d    = new_e;
          main_id_d = in_instID;
        end else if (accept) begin
          skid_d    = new_e;
          skid_id_d = in_instID;
          state_d   = FULL;
        end else if (handoff) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // The skid entry is promoted with this cycle's snoop already applied.
        if (handoff) begin
          main_d    = skid_snp;
          main_id_d = skid_id_q;
          state_d   = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      main_id_q <= '0;
      skid_id_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      main_id_q <= main_id_d;
      skid_id_q <= skid_id_d;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.opcode;
  assign out_rd       = main_q.rd;
  assign out_rd_vld   = main_q.rd_vld;
  assign out_imm      = main_q.imm;
  assign out_instID   = main_id_q;
  assign out_csr      = main_q.csr;
  assign out_csr_vld  = main_q.csr_vld;
  assign out_rs1_data = main_q.rs1_data;
  assign out_rs2_data = main_q.rs2_data;
  assign dbg_state    = state_q;

endmodule

// File: doc/exe_operand_fetch.md
# exe_operand_fetch

Execute-side consumer of the registered decode bundle. Accepts one decoded instruction per cycle over a valid/ready handshake and reads rs1/rs2 from an internal 32×32 register file. Absorbs writeback updates, including updates to entries already captured. Presents a registered issue bundle, with operand data, to the ALU through a two-entry (main + skid) output buffer.

## Interface

Parameters:
- INST_ID_W, default `InstIDDepth`: width of the instruction-ID field.

Ports:
- clk  in  1  rising-edge clock, the single clock of the block
- rst_n  in  1  reset; synchronous, active-low
- in_vld  in  1  decode bundle valid
- in_rdy  out  1  block can accept; `in_rdy = !skid_vld` (registered)
- in_pc / in_opcode / in_rs1 / in_rs2 / in_rd / in_rd_vld / in_imm / in_instID / in_csr / in_csr_vld  in  32/7/5/5/5/1/32/INST_ID_W/12/1  decode bundle
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write index
- wb_data  in  32  write data
- flush  in  1  discard all buffered entries
- out_vld  out  1  issue bundle valid
- out_rdy  in  1  ALU accepts
- out_pc / out_opcode / out_rd / out_rd_vld / out_imm / out_instID / out_csr / out_csr_vld  out  as inputs  forwarded bundle
- out_rs1_data, out_rs2_data  out  32  operand values

## Operation

- Transfers:
  - accept = in_vld & in_rdy & !flush
  - handoff = out_vld & out_rdy
- Buffer states:
  - EMPTY: main invalid, skid invalid
  - BUSY: main valid, skid invalid
  - FULL: main valid, skid valid
- Transitions:
  - EMPTY, accept → BUSY
  - BUSY, accept & handoff → BUSY (main replaced)
  - BUSY, accept & !handoff → FULL (new entry into skid)
  - BUSY, !accept & handoff → EMPTY
  - FULL, handoff → BUSY (skid moves to main); in FULL, in_rdy=0, so accept cannot occur
  - flush → EMPTY from any state, overriding all other transitions
- Operand read at accept: rsX_data = (rsX==0) ? 0 : rf[rsX].
- Register file:
  - x0 reads 0 and is never written.
  - Write on wb_en & wb_rd≠0 at the clock edge.
  - Writeback proceeds regardless of flush and buffer state.
- Held-entry snoop: every cycle, for each valid main/skid entry not being handed off, wb_en & wb_rd≠0 & wb_rd==rsX replaces the captured rsX_data with wb_data. Main and skid each store their own rs1/rs2 indices for this comparison.
- Simultaneous handoff and snoop on main: the handed-off value is the pre-snoop value. If the skid entry moves to main in the same cycle, it carries the snooped value.
- out_* always reflect the main entry. They hold stable while out_vld & !out_rdy.

## Timing

- Reset (rst_n=0 at an edge):
  - State → EMPTY.
  - out_vld=0, in_rdy=1.
  - All out_* data fields = 0.
  - All 32 registers cleared to 0.
  - Reset mid-transfer drops both entries.
- Latency: accepted at edge N → out_vld=1 during cycle N+1.
- Throughput: one instruction per cycle while out_rdy=1.
- in_rdy falls in the cycle after entry to FULL and rises in the cycle after FULL→BUSY.
- flush: out_vld=0 and in_rdy=1 in the cycle after the flush edge. An input offered during the flush cycle is not accepted.

## Configuration

- WB_BYPASS_EN defined: same-cycle bypass at accept. If wb_en & wb_rd≠0 & wb_rd==rsX in the accept cycle, the captured rsX_data = wb_data.
- WB_BYPASS_EN undefined: the captured value is the pre-write rf[rsX]. The upstream pipeline must then avoid this read-during-write case. Held-entry snoop stays active in both builds.

## Structure

- Shared defines (inc/defines.v):
  - `InstIDDepth`
  - XLEN (32)
  - REG_NUM (32)
  - buffer state encodings: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2
- Sub-module `exe_regfile`:
  - 32×32 storage
  - two combinational read ports (x0 forced to 0)
  - one synchronous write port
  - synchronous active-low clear
- Main/skid entries, state logic and snoop comparators live in the top level.

## Test plan

- Reset, then write x5=0x1234 via wb; accept rs1=5, rs2=0 with out_rdy=1 → next cycle out_vld=1, out_rs1_data=0x1234, out_rs2_data=0.
- Hold out_rdy=0 and offer 3 back-to-back instructions (A, B, C) → A in main, B in skid, in_rdy=0; C waits. Raise out_rdy → A, B, C delivered in order, one per cycle, with no drop or duplicate.
- Held entry with rs1=7, out_rdy=0; wb x7=0xDEAD → out_rs1_data becomes 0xDEAD in the next cycle while out_vld stays 1.
- WB_BYPASS_EN build: wb x3=0xAA and accept rs2=3 in the same cycle → out_rs2_data=0xAA. Without the macro → old value 0.
- FULL state, assert flush for one cycle together with in_vld=1 → next cycle out_vld=0, in_rdy=1, and the offered instruction never appears.
- wb_en with wb_rd=0 and data 0xFFFF, then accept rs1=0 → out_rs1_data=0. Separately, pull rst_n low mid-stream → out_vld=0 and all registers read 0.
